// File: rtl/bcd_step_counter_pkg.sv
// Shared constants and helpers for the BCD step counter slice.
package bcd_pkg;
  localparam int unsigned BCD_W            = 4;
  localparam logic [3:0]  BCD_MAX          = 4'd9;
  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } op_e;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    return (v <= BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_step_counter_if.sv
// Button/switch inputs and digit/pulse outputs of the BCD step counter.
interface bcd_step_counter_if import bcd_pkg::*; ();
  logic             btn_up;
  logic             btn_dn;
  logic             btn_ld;
  logic [BCD_W-1:0] sw;
  logic [BCD_W-1:0] digit;
  logic             carry;
  logic             borrow;
  logic             ld_err;

  modport master (
    output btn_up, btn_dn, btn_ld, sw,
    input  digit, carry, borrow, ld_err
  );

  modport slave (
    input  btn_up, btn_dn, btn_ld, sw,
    output digit, carry, borrow, ld_err
  );
endinterface

// File: rtl/bcd_step_counter_btn_debounce.sv
// Per-button front end: two-flop synchroniser, counting debouncer, press-edge detect.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = bcd_pkg::DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // Any cycle agreeing with the stable level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_d;
endmodule

// File: rtl/bcd_step_counter.sv
// Single BCD digit driven by debounced up/down/load buttons, with chainable carry/borrow.
module bcd_step_counter import bcd_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_step_counter_if.slave  bus
);
  logic             press_up;
  logic             press_dn;
  logic             press_ld;
  logic [2:0]       unused_levels;
  logic [BCD_W-1:0] digit_q;
  logic             carry_q;
  logic             borrow_q;
  logic             ld_err_q;
  op_e              op;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_up), .level(unused_levels[0]), .press(press_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_dn), .level(unused_levels[1]), .press(press_dn)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ld (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_ld), .level(unused_levels[2]), .press(press_ld)
  );

  // Load wins outright; simultaneous up+down cancel to no-op.
  always_comb begin
    op = OP_NONE;
    if (press_ld)                  op = OP_LOAD;
    else if (press_up && !press_dn) op = OP_INC;
    else if (press_dn && !press_up) op = OP_DEC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ld_err_q <= 1'b0;
      unique case (op)
        OP_LOAD: begin
          if (bcd_valid(bus.sw)) digit_q  <= bus.sw;
          else                   ld_err_q <= 1'b1;
        end
        OP_INC: begin
          if (digit_q == BCD_MAX) begin
            digit_q <= '0;
            carry_q <= 1'b1;
          end else begin
            digit_q <= digit_q + BCD_W'(1);
          end
        end
        OP_DEC: begin
          if (digit_q == '0) begin
            digit_q  <= BCD_MAX;
            borrow_q <= 1'b1;
          end else begin
            digit_q <= digit_q - BCD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.digit  = digit_q;
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.ld_err = ld_err_q;
endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench for bcd_step_counter with DEBOUNCE_CYCLES = 4.
module tb_bcd_step_counter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_step_counter_if bus_if ();

  bcd_step_counter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input logic up, input logic dn, input logic ld);
    bus_if.btn_up = up;
    bus_if.btn_dn = dn;
    bus_if.btn_ld = ld;
  endtask

  // Raise the given raw buttons, then advance through edges 1..6 after the rise.
  task automatic raise_and_wait(input logic up, input logic dn, input logic ld);
    set_buttons(up, dn, ld);
    repeat (6) tick();
  endtask

  // Drop all buttons and let the release debounce settle.
  task automatic release_all();
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      set_buttons(i[0], ~i[0], i[0]);
      tick();
      checks++;
      if (bus_if.digit !== 4'd0 || bus_if.carry !== 1'b0 || bus_if.borrow !== 1'b0 || bus_if.ld_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: digit=%0d c=%b b=%b e=%b, required digit=0 all pulses 0",
                 i, bus_if.digit, bus_if.carry, bus_if.borrow, bus_if.ld_err);
      end
    end
    set_buttons(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus_if.digit !== 4'd0 || bus_if.carry !== 1'b0 || bus_if.borrow !== 1'b0 || bus_if.ld_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: digit=%0d c=%b b=%b e=%b, required digit=0 all pulses 0",
                 i, bus_if.digit, bus_if.carry, bus_if.borrow, bus_if.ld_err);
      end
    end
  endtask

  task automatic test_increment_wrap();
    logic [3:0] prev;
    logic [3:0] want;
    for (int unsigned i = 1; i <= 10; i++) begin
      prev = 4'(i - 1);
      want = 4'(i % 10);
      raise_and_wait(1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_if.digit !== prev) begin
        errors++;
        $display("FAIL inc_early step %0d: digit=%0d at edge 6, required %0d", i, bus_if.digit, prev);
      end
      tick();
      checks++;
      if (bus_if.digit !== want || bus_if.carry !== (i == 10)) begin
        errors++;
        $display("FAIL inc_update step %0d: digit=%0d carry=%b, required digit=%0d carry=%b",
                 i, bus_if.digit, bus_if.carry, want, (i == 10));
      end
      tick();
      checks++;
      if (bus_if.carry !== 1'b0 || bus_if.digit !== want) begin
        errors++;
        $display("FAIL inc_after step %0d: digit=%0d carry=%b, required digit=%0d carry=0",
                 i, bus_if.digit, bus_if.carry, want);
      end
      release_all();
    end
  endtask

  task automatic test_bounce();
    logic seq [0:5];
    seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int unsigned i = 0; i < 6; i++) begin
      set_buttons(seq[i], 1'b0, 1'b0);
      tick();
    end
    set_buttons(1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus_if.digit !== 4'd0 || bus_if.carry !== 1'b0) begin
        errors++;
        $display("FAIL bounce_reject cycle %0d: digit=%0d carry=%b, required digit=0 carry=0",
                 i, bus_if.digit, bus_if.carry);
      end
    end
    set_buttons(1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    checks++;
    if (bus_if.digit !== 4'd1) begin
      errors++;
      $display("FAIL bounce_accept: digit=%0d, required 1", bus_if.digit);
    end
  endtask

  task automatic test_decrement_simultaneous();
    raise_and_wait(1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus_if.digit !== 4'd0 || bus_if.borrow !== 1'b0) begin
      errors++;
      $display("FAIL dec_plain: digit=%0d borrow=%b, required digit=0 borrow=0", bus_if.digit, bus_if.borrow);
    end
    release_all();
    raise_and_wait(1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus_if.digit !== 4'd9 || bus_if.borrow !== 1'b1) begin
      errors++;
      $display("FAIL dec_wrap: digit=%0d borrow=%b, required digit=9 borrow=1", bus_if.digit, bus_if.borrow);
    end
    tick();
    checks++;
    if (bus_if.borrow !== 1'b0) begin
      errors++;
      $display("FAIL dec_wrap_width: borrow=%b, required 0", bus_if.borrow);
    end
    release_all();
    set_buttons(1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus_if.digit !== 4'd9 || bus_if.carry !== 1'b0 || bus_if.borrow !== 1'b0) begin
        errors++;
        $display("FAIL up_dn_cancel cycle %0d: digit=%0d c=%b b=%b, required digit=9 pulses 0",
                 i, bus_if.digit, bus_if.carry, bus_if.borrow);
      end
    end
    release_all();
  endtask

  task automatic test_load();
    bus_if.sw = 4'd7;
    raise_and_wait(1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_if.digit !== 4'd7 || bus_if.ld_err !== 1'b0) begin
      errors++;
      $display("FAIL load_7: digit=%0d ld_err=%b, required digit=7 ld_err=0", bus_if.digit, bus_if.ld_err);
    end
    release_all();

    bus_if.sw = 4'd12;
    raise_and_wait(1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_if.digit !== 4'd7 || bus_if.ld_err !== 1'b1) begin
      errors++;
      $display("FAIL load_12: digit=%0d ld_err=%b, required digit=7 ld_err=1", bus_if.digit, bus_if.ld_err);
    end
    tick();
    checks++;
    if (bus_if.ld_err !== 1'b0) begin
      errors++;
      $display("FAIL load_12_width: ld_err=%b, required 0", bus_if.ld_err);
    end
    release_all();

    bus_if.sw = 4'd9;
    raise_and_wait(1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_if.digit !== 4'd9 || bus_if.ld_err !== 1'b0) begin
      errors++;
      $display("FAIL load_9: digit=%0d ld_err=%b, required digit=9 ld_err=0", bus_if.digit, bus_if.ld_err);
    end
    release_all();

    bus_if.sw = 4'd3;
    raise_and_wait(1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_if.digit !== 4'd3 || bus_if.carry !== 1'b0 || bus_if.ld_err !== 1'b0) begin
      errors++;
      $display("FAIL load_over_up: digit=%0d carry=%b ld_err=%b, required digit=3 carry=0 ld_err=0",
               bus_if.digit, bus_if.carry, bus_if.ld_err);
    end
    release_all();
  endtask

  task automatic test_held_through_reset();
    set_buttons(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus_if.digit !== 4'd0) begin
      errors++;
      $display("FAIL held_reset_clear: digit=%0d, required 0", bus_if.digit);
    end
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (bus_if.digit !== 4'd0) begin
      errors++;
      $display("FAIL held_early: digit=%0d at edge 6 after release, required 0", bus_if.digit);
    end
    tick();
    checks++;
    if (bus_if.digit !== 4'd1) begin
      errors++;
      $display("FAIL held_press: digit=%0d at edge 7 after release, required 1", bus_if.digit);
    end
    repeat (10) tick();
    checks++;
    if (bus_if.digit !== 4'd1) begin
      errors++;
      $display("FAIL held_no_repeat: digit=%0d, required 1", bus_if.digit);
    end
    release_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.sw = 4'd0;
    set_buttons(1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_increment_wrap();
    test_bounce();
    test_decrement_simultaneous();
    test_load();
    test_held_through_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
